spi_mem_burst: RTL

Parametrised SPI slave memory, successor to the team's fixed 8-bit SPI memory. It takes a serial command frame of address and R/W bit, then reads or writes an on-chip register-file memory. It adds configurable address/data width, burst auto-increment with wrap, abort on chip-select release, and no dummy cycle before read data. It sits behind the board SPI pins in the `clk` domain and drives the status LEDs.

---
 rtl/spi_mem_burst.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/spi_mem_burst.sv
// SPI mode-0 slave in front of a register-file memory: command frame of address + R/W,
// then burst writes or burst reads with address auto-increment and wrap.
module spi_mem_burst #(
  parameter int ADDR_WIDTH  = 7,
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sclk_pin,
  input  logic       cs_pin,
  input  logic       mosi_pin,
  output logic       miso_pin,
  output logic [3:0] leds
);

  localparam int MAXB = (ADDR_WIDTH + 1 > DATA_WIDTH) ? ADDR_WIDTH + 1 : DATA_WIDTH;
  localparam int CW   = $clog2(MAXB);
  localparam logic [CW-1:0] CMD_LAST  = CW'(ADDR_WIDTH);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CMD, WRITE, READ} state_t;
  state_t state, next_state;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_d;
  logic                   sclk_s, mosi_s, cs_high, sclk_rise, sclk_fall;

  logic [CW-1:0]         bit_cnt;
  logic [ADDR_WIDTH-1:0] cmd_sr, addr, addr_inc;
  logic [DATA_WIDTH-1:0] shift_reg, wr_word;
  logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH) - 1];
  logic                  cmd_done, wr_commit, rd_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_pin};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_pin};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_pin};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign cs_high   = cs_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign addr_inc  = addr + ADDR_WIDTH'(1);
  assign wr_word   = {shift_reg[DATA_WIDTH-2:0], mosi_s};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // CS release overrides every other event, including a coincident SCLK edge.
  always_comb begin
    next_state = state;
    cmd_done   = 1'b0;
    wr_commit  = 1'b0;
    rd_next    = 1'b0;
    if (cs_high) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:  next_state = CMD;
        CMD: begin
          if (sclk_rise && bit_cnt == CMD_LAST) begin
            cmd_done   = 1'b1;
            next_state = mosi_s ? READ : WRITE;
          end
        end
        WRITE: wr_commit = sclk_rise && (bit_cnt == DATA_LAST);
        READ:  rd_next   = sclk_fall && (bit_cnt == DATA_LAST);
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt   <= '0;
      cmd_sr    <= '0;
      addr      <= '0;
      shift_reg <= '0;
      miso_pin  <= 1'b0;
      leds      <= 4'h0;
    end else if (cs_high || state == IDLE) begin
      bit_cnt  <= '0;
      miso_pin <= 1'b0;
    end else begin
      case (state)
        CMD: begin
          if (cmd_done) begin
            addr      <= cmd_sr;
            bit_cnt   <= '0;
            shift_reg <= mem[cmd_sr];
          end else if (sclk_rise) begin
            cmd_sr  <= {cmd_sr[ADDR_WIDTH-2:0], mosi_s};
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        WRITE: begin
          if (wr_commit) begin
            shift_reg <= wr_word;
            leds      <= wr_word[3:0];
            addr      <= addr_inc;
            bit_cnt   <= '0;
          end else if (sclk_rise) begin
            shift_reg <= wr_word;
            bit_cnt   <= bit_cnt + CW'(1);
          end
        end
        READ: begin
          // Each fall presents the current MSB; the last bit of a word also preloads the next word.
          if (sclk_fall) begin
            miso_pin <= shift_reg[DATA_WIDTH-1];
            if (rd_next) begin
              addr      <= addr_inc;
              shift_reg <= mem[addr_inc];
              bit_cnt   <= '0;
            end else begin
              shift_reg <= {shift_reg[DATA_WIDTH-2:0], 1'b0};
              bit_cnt   <= bit_cnt + CW'(1);
            end
          end
        end
        default: bit_cnt <= '0;
      endcase
    end
  end

  // Memory contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_commit) mem[addr] <= wr_word;
  end

endmodule
